// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: frame header tag, framer states
// and the byte-count and header helpers used by the serializer.
package alu_pkg;

  localparam logic [3:0] ALU_HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } ser_state_t;

  // Number of payload bytes in a frame for a given result width.
  function automatic int BYTES(input int width);
    return width / 8;
  endfunction

  function automatic logic [7:0] aluHeader(input logic carry);
    return {ALU_HDR_TAG, 3'b000, carry};
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Small synchronous first-word-fall-through FIFO holding {carry, result} entries.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module alu_result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_doWrite;
  logic             w_doRead;

  assign empty = (r_wrPtr == r_rdPtr);
  assign full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);

  // A write into a full FIFO is legal only when the head leaves on the same edge.
  assign w_doRead  = rd_en && !empty;
  assign w_doWrite = wr_en && (!full || w_doRead);

  assign dout = r_mem[r_rdPtr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doWrite) r_wrPtr <= r_wrPtr + (AW+1)'(1);
      if (w_doRead)  r_rdPtr <= r_rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doWrite) r_mem[r_wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Buffers ALU results and streams each one as a header byte plus result bytes
// (MSB first) over a valid/ready byte interface; overflow drops and flags.
module alu_result_serializer #(
  parameter int OUT_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OUT_DATA_WIDTH-1:0] Arith_OUT,
  input  logic                      Carry_OUT,
  input  logic                      Arith_Flag,
  input  logic                      CLR_DROP,
  output logic [7:0]                TX_DATA,
  output logic                      TX_VALID,
  input  logic                      TX_READY,
  output logic                      DROP,
  output logic                      BUSY
);

  import alu_pkg::*;

  localparam int NBYTES = BYTES(OUT_DATA_WIDTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  ser_state_t                r_state;
  ser_state_t                w_nextState;
  logic [OUT_DATA_WIDTH-1:0] r_frame;
  logic [OUT_DATA_WIDTH-1:0] w_nextFrame;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          w_nextIdx;
  logic [7:0]                r_txData;
  logic [7:0]                w_nextData;
  logic                      r_txValid;
  logic                      w_nextValid;
  logic                      r_drop;
  logic                      w_pop;
  logic                      w_accept;
  logic                      w_wrEn;
  logic                      w_dropSet;
  logic                      w_fifoFull;
  logic                      w_fifoEmpty;
  logic [OUT_DATA_WIDTH:0]   w_head;

  // Index 0 selects the most significant result byte.
  function automatic logic [7:0] frameByte(input logic [OUT_DATA_WIDTH-1:0] frame,
                                           input logic [IDX_W-1:0] idx);
    return 8'(frame >> (8 * (NBYTES - 1 - int'(idx))));
  endfunction

  assign w_accept  = r_txValid && TX_READY;
  assign w_wrEn    = Arith_Flag && (!w_fifoFull || w_pop);
  assign w_dropSet = Arith_Flag && w_fifoFull && !w_pop;

  alu_result_fifo #(
    .WIDTH (OUT_DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .wr_en (w_wrEn),
    .din   ({Carry_OUT, Arith_OUT}),
    .rd_en (w_pop),
    .full  (w_fifoFull),
    .empty (w_fifoEmpty),
    .dout  (w_head)
  );

  always_comb begin
    w_nextState = r_state;
    w_nextFrame = r_frame;
    w_nextIdx   = r_idx;
    w_nextData  = r_txData;
    w_nextValid = r_txValid;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_fifoEmpty) begin
          w_pop       = 1'b1;
          w_nextFrame = w_head[OUT_DATA_WIDTH-1:0];
          w_nextData  = aluHeader(w_head[OUT_DATA_WIDTH]);
          w_nextValid = 1'b1;
          w_nextState = HDR;
        end
      end
      HDR: begin
        if (w_accept) begin
          w_nextIdx   = '0;
          w_nextData  = frameByte(r_frame, '0);
          w_nextState = DATA;
        end
      end
      DATA: begin
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            // Chain straight into the next frame so there is no idle gap.
            if (!w_fifoEmpty) begin
              w_pop       = 1'b1;
              w_nextFrame = w_head[OUT_DATA_WIDTH-1:0];
              w_nextData  = aluHeader(w_head[OUT_DATA_WIDTH]);
              w_nextState = HDR;
            end else begin
              w_nextValid = 1'b0;
              w_nextData  = 8'h00;
              w_nextState = IDLE;
            end
          end else begin
            w_nextIdx  = r_idx + IDX_W'(1);
            w_nextData = frameByte(r_frame, r_idx + IDX_W'(1));
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_frame   <= '0;
      r_idx     <= '0;
      r_txData  <= '0;
      r_txValid <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_frame   <= w_nextFrame;
      r_idx     <= w_nextIdx;
      r_txData  <= w_nextData;
      r_txValid <= w_nextValid;
    end
  end

  // A new drop on the same edge as a clear request keeps the flag set.
  always_ff @(posedge CLK) begin
    if (!RST)           r_drop <= 1'b0;
    else if (w_dropSet) r_drop <= 1'b1;
    else if (CLR_DROP)  r_drop <= 1'b0;
  end

  assign TX_DATA  = r_txData;
  assign TX_VALID = r_txValid;
  assign DROP     = r_drop;
  assign BUSY     = (r_state != IDLE) || !w_fifoEmpty;

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed bench for alu_result_serializer: a queue-based model of buffered
// results and outgoing frame bytes is compared against the DUT every cycle.
module tb_alu_result_serializer;

  localparam int W     = 32;
  localparam int DEPTH = 2;

  logic          CLK;
  logic          RST;
  logic [W-1:0]  Arith_OUT;
  logic          Carry_OUT;
  logic          Arith_Flag;
  logic          CLR_DROP;
  logic [7:0]    TX_DATA;
  logic          TX_VALID;
  logic          TX_READY;
  logic          DROP;
  logic          BUSY;

  int checks   = 0;
  int failures = 0;
  bit checkEn  = 0;

  logic [W:0]    mFifo[$];
  logic [7:0]    mFrame[$];
  bit            mValid = 0;
  bit            mDrop  = 0;

  logic [7:0]    acceptedLog[$];
  logic [7:0]    expLog[$];

  alu_result_serializer #(
    .OUT_DATA_WIDTH (W),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Arith_OUT  (Arith_OUT),
    .Carry_OUT  (Carry_OUT),
    .Arith_Flag (Arith_Flag),
    .CLR_DROP   (CLR_DROP),
    .TX_DATA    (TX_DATA),
    .TX_VALID   (TX_VALID),
    .TX_READY   (TX_READY),
    .DROP       (DROP),
    .BUSY       (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] data, input logic carry, input logic flag,
                               input logic ready, input logic clr);
    Arith_OUT  = data;
    Carry_OUT  = carry;
    Arith_Flag = flag;
    TX_READY   = ready;
    CLR_DROP   = clr;
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "_len"}, 32'(acceptedLog.size()), 32'(expLog.size()));
    foreach (expLog[i])
      checkOutput($sformatf("%s_b%0d", name, i),
                  (i < acceptedLog.size()) ? {24'h0, acceptedLog[i]} : 32'hFFFF_FFFF,
                  {24'h0, expLog[i]});
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    bit done = 0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      @(negedge CLK);
      if (BUSY === 1'b0) done = 1;
    end
    checkOutput({name, "_idle"}, {31'h0, BUSY}, 32'h0);
  endtask

  function automatic void loadFrame(input logic [W:0] e);
    mFrame.delete();
    mFrame.push_back({4'hA, 3'b000, e[W]});
    for (int k = 0; k < W / 8; k++) mFrame.push_back(e[W-1-8*k -: 8]);
  endfunction

  // Model: results wait in a bounded queue, the current frame is a byte queue
  // consumed on each handshake, and a new frame starts once the old one is gone.
  always @(posedge CLK) begin
    bit setD;
    if (!RST) begin
      mFifo.delete();
      mFrame.delete();
      mValid = 0;
      mDrop  = 0;
    end else begin
      if (mValid && TX_READY) begin
        void'(mFrame.pop_front());
        if (mFrame.size() == 0) mValid = 0;
      end
      if (!mValid && mFifo.size() != 0) begin
        loadFrame(mFifo.pop_front());
        mValid = 1;
      end
      setD = 0;
      if (Arith_Flag) begin
        if (mFifo.size() < DEPTH) mFifo.push_back({Carry_OUT, Arith_OUT});
        else setD = 1;
      end
      if (setD) mDrop = 1;
      else if (CLR_DROP) mDrop = 0;
    end
  end

  always @(negedge CLK) begin
    if (checkEn) begin
      checkOutput("m_tx_valid", {31'h0, TX_VALID}, {31'h0, mValid});
      if (mValid) checkOutput("m_tx_data", {24'h0, TX_DATA}, {24'h0, mFrame[0]});
      checkOutput("m_drop", {31'h0, DROP}, {31'h0, mDrop});
      checkOutput("m_busy", {31'h0, BUSY}, {31'h0, (mValid || mFifo.size() != 0)});
      if (TX_VALID === 1'b1 && TX_READY === 1'b1) acceptedLog.push_back(TX_DATA);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int run;
    bit started;
    bit ended;

    RST = 1'b0;
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    checkEn = 1;
    @(negedge CLK);
    checkOutput("rst_valid", {31'h0, TX_VALID}, 32'h0);
    checkOutput("rst_data",  {24'h0, TX_DATA},  32'h0);
    checkOutput("rst_drop",  {31'h0, DROP},     32'h0);
    checkOutput("rst_busy",  {31'h0, BUSY},     32'h0);
    RST = 1'b1;
    @(negedge CLK);

    $display("[TB] single result, ready held high");
    acceptedLog.delete();
    applyStimulus(32'h0000_0008, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t1_lat_not_yet", {31'h0, TX_VALID}, 32'h0);
    @(negedge CLK);
    checkOutput("t1_hdr_valid", {31'h0, TX_VALID}, 32'h1);
    checkOutput("t1_hdr_data",  {24'h0, TX_DATA},  32'hA0);
    repeat (4) begin
      @(negedge CLK);
      checkOutput("t1_body_valid", {31'h0, TX_VALID}, 32'h1);
    end
    @(negedge CLK);
    checkOutput("t1_end_valid", {31'h0, TX_VALID}, 32'h0);
    checkOutput("t1_end_busy",  {31'h0, BUSY},     32'h0);
    expLog = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h08};
    checkLog("t1");

    $display("[TB] carry set");
    acceptedLog.delete();
    applyStimulus(32'h0001_0000, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle("t2", 20);
    expLog = '{8'hA1, 8'h00, 8'h01, 8'h00, 8'h00};
    checkLog("t2");

    $display("[TB] backpressure");
    acceptedLog.delete();
    applyStimulus(32'h1234_5678, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    for (int i = 0; i < 40; i++) begin
      bit [3:0] pat;
      pat = 4'b1001;
      applyStimulus('0, 1'b0, 1'b0, pat[i % 4], 1'b0);
      @(negedge CLK);
    end
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle("t3", 20);
    expLog = '{8'hA0, 8'h12, 8'h34, 8'h56, 8'h78};
    checkLog("t3");

    $display("[TB] overflow with four consecutive results");
    acceptedLog.delete();
    run = 0;
    started = 0;
    ended = 0;
    applyStimulus(32'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (!ended) begin
        if (TX_VALID === 1'b1) begin
          started = 1;
          run++;
        end else if (started) begin
          ended = 1;
        end
      end
      if (i < 3) applyStimulus(32'(i + 2), 1'b0, 1'b1, 1'b1, 1'b0);
      else       applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("t4_back_to_back", 32'(run), 32'd15);
    checkOutput("t4_drop_set", {31'h0, DROP}, 32'h1);
    expLog = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h01,
               8'hA0, 8'h00, 8'h00, 8'h00, 8'h02,
               8'hA0, 8'h00, 8'h00, 8'h00, 8'h03};
    checkLog("t4");
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge CLK);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("t4_drop_cleared", {31'h0, DROP}, 32'h0);

    // Stall the consumer so the FIFO fills, then drop and clear on one edge.
    applyStimulus(32'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    applyStimulus(32'd6, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    applyStimulus(32'd7, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    applyStimulus(32'd8, 1'b0, 1'b1, 1'b0, 1'b1);
    @(negedge CLK);
    applyStimulus('0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t4_set_wins", {31'h0, DROP}, 32'h1);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle("t4_drain", 40);
    checkOutput("t4_drop_held", {31'h0, DROP}, 32'h1);

    $display("[TB] reset mid-frame");
    acceptedLog.delete();
    applyStimulus(32'hCAFE_BABE, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    checkOutput("t5_rst_valid", {31'h0, TX_VALID}, 32'h0);
    checkOutput("t5_rst_data",  {24'h0, TX_DATA},  32'h0);
    checkOutput("t5_rst_drop",  {31'h0, DROP},     32'h0);
    checkOutput("t5_rst_busy",  {31'h0, BUSY},     32'h0);
    @(negedge CLK);
    acceptedLog.delete();
    applyStimulus(32'h0BAD_F00D, 1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    applyStimulus('0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitIdle("t5", 20);
    expLog = '{8'hA0, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
    checkLog("t5");

    checkEn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_result_serializer.md
# alu_result_serializer

Downstream stage of the ALU arithmetic unit. Captures each registered arithmetic result (`Arith_OUT`, `Carry_OUT`) qualified by `Arith_Flag` into a small FIFO. Emits each result as a byte-wide framed stream with a valid/ready handshake toward the UART/register-file side. Overflow is absorbed by dropping the new result and raising a sticky flag; it never stalls the ALU.

## Interface
Parameters:
- `OUT_DATA_WIDTH`, 32: result width. Must be a multiple of 8.
- `FIFO_DEPTH`, 2: result buffer entries. Must be a power of two and ≥2.

Ports:
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `Arith_OUT`  in  OUT_DATA_WIDTH  result from the arithmetic unit.
- `Carry_OUT`  in  1  carry bit from the arithmetic unit.
- `Arith_Flag`  in  1  result valid. Sampled every edge; may be high on consecutive cycles.
- `CLR_DROP`  in  1  clears `DROP`.
- `TX_DATA`  out  8  current frame byte.
- `TX_VALID`  out  1  `TX_DATA` is valid.
- `TX_READY`  in  1  consumer accepts the byte.
- `DROP`  out  1  sticky: at least one result was lost.
- `BUSY`  out  1  FIFO non-empty or a frame is in progress.

## Operation
- Frame layout: `BYTES = OUT_DATA_WIDTH/8`; frame length is `1+BYTES`.
  - Header byte 0 = `{4'hA, 3'b000, carry}`.
  - Then the result, MSB byte first.
- FIFO write: occurs when `Arith_Flag`=1 and either (FIFO not full) or (FIFO full and a pop occurs on the same edge). Stored entry is `{Carry_OUT, Arith_OUT}`.
- Drop: if `Arith_Flag`=1, the FIFO is full and there is no pop on that edge, the result is discarded and `DROP` is set.
  - `DROP` stays set until `CLR_DROP`=1.
  - If a set and `CLR_DROP` occur on the same edge, set wins.
- FSM states: `IDLE`, `HDR`, `DATA`.
  - `IDLE` → `HDR`: FIFO non-empty. Pop the head into the frame register, `TX_VALID`=1, `TX_DATA`=header.
  - `HDR` → `DATA`: header accepted (`TX_VALID`&`TX_READY`). Byte index = 0, which is the MSB byte.
  - `DATA`: on acceptance, advance the index.
    - On the last byte: if FIFO non-empty, pop the next entry and go to `HDR` (back-to-back, no idle cycle).
    - Otherwise go to `IDLE` with `TX_VALID`=0.
- Handshake: `TX_DATA` and `TX_VALID` are registered. While `TX_VALID`=1 and `TX_READY`=0, `TX_DATA` holds stable. `TX_VALID` never drops before acceptance.
- `BUSY` = (state≠`IDLE`) | FIFO non-empty.
- Reset, including mid-frame: the next edge with `RST`=0 forces `IDLE`, empties the FIFO (in-flight frame abandoned), and sets `TX_DATA`=0, `TX_VALID`=0, `DROP`=0, `BUSY`=0.

## Timing
- `Arith_Flag` sampled high at edge N → entry written at edge N.
- Header is visible with `TX_VALID`=1 after edge N+1 when the FSM is idle. Latency is 2 edges.
- Best-case frame: `1+BYTES` cycles with `TX_READY` held high (5 cycles at the default width).
- Sustained throughput: one result per `1+BYTES` cycles. A continuously enabled ALU overflows the FIFO, and the excess results are dropped.
- Pop occurs on the same edge as the `IDLE`→`HDR` transition or the last-byte acceptance. The full-FIFO write-with-pop rule above applies on that edge.

## Structure
- Shared package `alu_pkg`:
  - `ALU_HDR_TAG = 4'hA`
  - FSM state typedef (`IDLE`/`HDR`/`DATA`)
  - frame-length helper `BYTES`
- Sub-module `alu_result_fifo`: synchronous FIFO with `FIFO_DEPTH` entries, width `OUT_DATA_WIDTH+1`.
  - Pointers are `log2(FIFO_DEPTH)+1` bits, giving wrap-around full/empty detection.
  - Ports: `wr_en`, `rd_en`, `full`, `empty`, `dout` (head, first-word-fall-through).
- Top level holds the FSM, frame register, byte index, `DROP`, and output registers.

## Test plan
- Single result with `TX_READY`=1: `Arith_OUT`=0x0000_0008, carry 0, one `Arith_Flag` pulse. Expect bytes A0,00,00,00,08 on 5 consecutive cycles, first `TX_VALID` 2 edges after the flag, then `BUSY`=0.
- Carry: `Arith_OUT`=0x0001_0000, `Carry_OUT`=1. Expect A1,00,01,00,00.
- Backpressure: `TX_READY` toggles 1,0,0,1,… during a frame for 0x1234_5678. Expect each byte held stable while stalled, sequence A0,12,34,56,78, no duplicates or skips.
- Overflow: 4 consecutive flags (values 1,2,3,4), `TX_READY`=1. Expect frames for 1, 2 and 3 back-to-back with no idle cycle, 4 dropped, `DROP`=1. A `CLR_DROP` pulse then clears it. A set and clear on the same edge keeps `DROP`=1.
- Reset mid-frame: `RST`=0 for 1 cycle after the 2nd byte. Expect all outputs 0, FIFO empty. A new result afterwards produces a clean, full 5-byte frame.
